// File: rtl/bird_physics.sv
// Vertical motion engine for the bird: Y position, signed velocity and
// IDLE/PLAY/DEAD game state. Everything runs on the master clock. clk_game
// and flap_btn are synchronised and edge-detected here; they are not used
// as clocks.
module bird_physics #(
  parameter int unsigned Y_START   = 240,
  parameter int unsigned FLOOR_Y   = 464,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned FLAP_VEL  = 6,
  parameter int unsigned MAX_FALL  = 8,
  parameter int unsigned DEAD_HOLD = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       clk_game,
  input  logic       flap_btn,
  input  logic       collide,
  output logic [9:0] bird_y,
  output logic [7:0] bird_vel,
  output logic [1:0] state,
  output logic       alive
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StDead = 2'b10
  } state_e;

  localparam int unsigned HoldW = $clog2(DEAD_HOLD + 1);

  localparam logic        [9:0]       YStart  = 10'(Y_START);
  localparam logic        [9:0]       FloorY  = 10'(FLOOR_Y);
  localparam logic signed [7:0]       Gravity = 8'(GRAVITY);
  localparam logic signed [7:0]       MaxFall = 8'(MAX_FALL);
  localparam logic signed [7:0]       FlapMag = 8'(FLAP_VEL);
  localparam logic signed [7:0]       VelFlap = 8'sd0 - FlapMag;
  localparam logic        [HoldW-1:0] HoldMax = HoldW'(DEAD_HOLD);

  // Sync chains: bit 0 = first sync flop, bit 1 = second, bit 2 = edge delay.
  logic [2:0] game_sync_q, game_sync_d;
  logic [2:0] flap_sync_q, flap_sync_d;
  logic       tick;
  logic       flap_edge;

  logic [9:0]       bird_y_q, bird_y_d;
  logic [7:0]       bird_vel_q, bird_vel_d;
  state_e           state_q, state_d;
  logic             flap_pending_q, flap_pending_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic signed [10:0] sum;
  logic signed [7:0]  vel_grav;
  logic signed [7:0]  vel_fall;
  logic        [7:0]  vel_next;

  // Shift the asynchronous inputs through their synchronisers.
  always_comb begin
    game_sync_d = {game_sync_q[1:0], clk_game};
    flap_sync_d = {flap_sync_q[1:0], flap_btn};
  end

  assign tick      = game_sync_q[1] & ~game_sync_q[2];
  assign flap_edge = flap_sync_q[1] & ~flap_sync_q[2];

  // Synchroniser and edge-detect flops.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      game_sync_q <= '0;
      flap_sync_q <= '0;
    end else begin
      game_sync_q <= game_sync_d;
      flap_sync_q <= flap_sync_d;
    end
  end

  // Physics arithmetic: 11-bit signed sum keeps the ceiling overshoot negative.
  always_comb begin
    sum      = $signed({1'b0, bird_y_q}) + $signed({{3{bird_vel_q[7]}}, bird_vel_q});
    vel_grav = $signed(bird_vel_q) + Gravity;
    vel_fall = (vel_grav > MaxFall) ? MaxFall : vel_grav;
    vel_next = (flap_pending_q || flap_edge) ? VelFlap : vel_fall;
  end

  // Game FSM and position/velocity next-state.
  always_comb begin
    state_d        = state_q;
    bird_y_d       = bird_y_q;
    bird_vel_d     = bird_vel_q;
    flap_pending_d = flap_pending_q;
    hold_d         = hold_q;

    case (state_q)
      StIdle: begin
        if (flap_edge) begin
          state_d        = StPlay;
          bird_vel_d     = VelFlap;
          flap_pending_d = 1'b0;
        end
      end

      StPlay: begin
        if (collide) begin
          // Collision wins over a coincident tick: no position update.
          state_d        = StDead;
          hold_d         = '0;
          flap_pending_d = 1'b0;
        end else if (tick) begin
          flap_pending_d = 1'b0;
          if (sum < 0) begin
            bird_y_d   = '0;
            bird_vel_d = '0;
          end else if (sum >= $signed({1'b0, FloorY})) begin
            bird_y_d   = FloorY;
            bird_vel_d = '0;
            state_d    = StDead;
            hold_d     = '0;
          end else begin
            bird_y_d   = sum[9:0];
            bird_vel_d = vel_next;
          end
        end else if (flap_edge) begin
          flap_pending_d = 1'b1;
        end
      end

      StDead: begin
        if (flap_edge && (hold_q == HoldMax)) begin
          state_d        = StIdle;
          bird_y_d       = YStart;
          bird_vel_d     = '0;
          flap_pending_d = 1'b0;
        end else if (tick && (hold_q != HoldMax)) begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      default: begin
        state_d        = StIdle;
        bird_y_d       = YStart;
        bird_vel_d     = '0;
        flap_pending_d = 1'b0;
      end
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= StIdle;
      bird_y_q       <= YStart;
      bird_vel_q     <= '0;
      flap_pending_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      bird_vel_q     <= bird_vel_d;
      flap_pending_q <= flap_pending_d;
      hold_q         <= hold_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    bird_y   = bird_y_q;
    bird_vel = bird_vel_q;
    state    = state_q;
    alive    = (state_q != StDead);
  end

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: reset, arc, terminal velocity, mid-flight
// reset, floor death, collision with dead-hold timing, and ceiling clamp.
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       clr;
  logic       clk_game;
  logic       flap_btn;
  logic       collide;
  logic [9:0] bird_y;
  logic [7:0] bird_vel;
  logic [1:0] state;
  logic       alive;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] ey;
  logic [7:0] ev;
  logic [1:0] es;
  logic       ea;

  int arc_y  [8] = '{234, 229, 225, 222, 220, 219, 219, 220};
  int arc_v  [8] = '{-5, -4, -3, -2, -1, 0, 1, 2};
  int term_y [9] = '{222, 225, 229, 234, 240, 247, 255, 263, 271};
  int term_v [9] = '{3, 4, 5, 6, 7, 8, 8, 8, 8};

  bird_physics dut (
    .clk      (clk),
    .clr      (clr),
    .clk_game (clk_game),
    .flap_btn (flap_btn),
    .collide  (collide),
    .bird_y   (bird_y),
    .bird_vel (bird_vel),
    .state    (state),
    .alive    (alive)
  );

  always #5 clk = ~clk;

  // One game tick, optionally with a coincident button press; returns at posedge+1.
  task automatic do_tick(input logic with_flap);
    @(negedge clk);
    clk_game = 1'b1;
    if (with_flap) flap_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clk_game = 1'b0;
    flap_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_flap();
    @(negedge clk);
    flap_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flap_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; clk_game = 1'b0; flap_btn = 1'b0; collide = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ey = 10'd240; ev = 8'd0; es = 2'b00; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL reset_state: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    @(negedge clk);
    clr = 1'b1;
    do_tick(1'b0);
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL idle_tick_ignored: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
  endtask

  task automatic test_start_arc();
    @(negedge clk);
    flap_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL start_not_early: got state=%b want state=00", state);
    end
    @(posedge clk);
    #1;
    ey = 10'd240; ev = 8'hFA; es = 2'b01; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL start_third_edge: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    @(negedge clk);
    flap_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b0);
      ey = 10'(arc_y[i]); ev = 8'(arc_v[i]);
      n_checks++;
      if ({bird_y, bird_vel} !== {ey, ev}) begin
        n_fail++;
        $display("FAIL arc_tick%0d: got y=%0d v=%0d want y=%0d v=%0d",
                 i + 1, bird_y, $signed(bird_vel), ey, $signed(ev));
      end
    end
  endtask

  task automatic test_terminal_vel();
    for (int i = 0; i < 9; i++) begin
      do_tick(1'b0);
      ey = 10'(term_y[i]); ev = 8'(term_v[i]);
      n_checks++;
      if ({bird_y, bird_vel} !== {ey, ev}) begin
        n_fail++;
        $display("FAIL terminal_tick%0d: got y=%0d v=%0d want y=%0d v=%0d",
                 i + 9, bird_y, $signed(bird_vel), ey, $signed(ev));
      end
      n_checks++;
      if ($signed(bird_vel) > 8) begin
        n_fail++;
        $display("FAIL terminal_cap%0d: got v=%0d want v<=8", i + 9, $signed(bird_vel));
      end
    end
  endtask

  task automatic test_reset_midflight();
    repeat (4) do_tick(1'b0);
    do_tick(1'b1);
    ey = 10'd311; ev = 8'hFA;
    n_checks++;
    if ({bird_y, bird_vel} !== {ey, ev}) begin
      n_fail++;
      $display("FAIL coincident_flap: got y=%0d v=%0d want y=%0d v=%0d",
               bird_y, $signed(bird_vel), ey, $signed(ev));
    end
    repeat (11) do_tick(1'b0);
    ey = 10'd300; ev = 8'd5; es = 2'b01; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL midflight_setup: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    // Assert reset between edges; outputs must change with no clock edge.
    #2;
    clr = 1'b0;
    #1;
    ey = 10'd240; ev = 8'd0; es = 2'b00; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL async_reset: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_floor();
    do_flap();
    do_tick(1'b0);
    do_tick(1'b1);
    ey = 10'd229; ev = 8'hFA;
    n_checks++;
    if ({bird_y, bird_vel} !== {ey, ev}) begin
      n_fail++;
      $display("FAIL floor_setup_flap: got y=%0d v=%0d want y=%0d v=%0d",
               bird_y, $signed(bird_vel), ey, $signed(ev));
    end
    repeat (42) do_tick(1'b0);
    ey = 10'd460; ev = 8'd8; es = 2'b01; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL floor_setup: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    do_tick(1'b0);
    ey = 10'd464; ev = 8'd0; es = 2'b10; ea = 1'b0;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL floor_death: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    do_tick(1'b0);
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL dead_frozen: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    repeat (31) do_tick(1'b0);
    do_flap();
    ey = 10'd240; ev = 8'd0; es = 2'b00; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL floor_restart: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
  endtask

  task automatic test_collision_hold();
    do_flap();
    for (int i = 0; i < 10; i++) do_tick(i == 4);
    ey = 10'd200; ev = 8'hFF; es = 2'b01; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL collide_setup: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    // Raise collide only in the cycle the tick strobe is high.
    @(negedge clk);
    clk_game = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    collide = 1'b1;
    @(posedge clk);
    #1;
    es = 2'b10; ea = 1'b0;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL collide_tick: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    @(negedge clk);
    collide = 1'b0;
    clk_game = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    repeat (10) do_tick(1'b0);
    do_flap();
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL hold_10: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    repeat (21) do_tick(1'b0);
    do_flap();
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL hold_31: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    do_tick(1'b0);
    do_flap();
    ey = 10'd240; ev = 8'd0; es = 2'b00; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL hold_32_idle: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
    do_flap();
    ev = 8'hFA; es = 2'b01;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL replay: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
  endtask

  task automatic test_ceiling();
    // Separate flap before each tick exercises the pending-flap path.
    for (int k = 1; k <= 40; k++) begin
      do_flap();
      do_tick(1'b0);
      ey = 10'(240 - 6 * k); ev = 8'hFA;
      n_checks++;
      if ({bird_y, bird_vel} !== {ey, ev}) begin
        n_fail++;
        $display("FAIL ceiling_tick%0d: got y=%0d v=%0d want y=%0d v=%0d",
                 k, bird_y, $signed(bird_vel), ey, $signed(ev));
      end
    end
    do_flap();
    do_tick(1'b0);
    ey = 10'd0; ev = 8'd0; es = 2'b01; ea = 1'b1;
    n_checks++;
    if ({bird_y, bird_vel, state, alive} !== {ey, ev, es, ea}) begin
      n_fail++;
      $display("FAIL ceiling_clamp: got y=%0d v=%0d s=%b a=%b want y=%0d v=%0d s=%b a=%b",
               bird_y, $signed(bird_vel), state, alive, ey, $signed(ev), es, ea);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start_arc();
    test_terminal_vel();
    test_reset_midflight();
    test_floor();
    test_collision_hold();
    test_ceiling();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Vertical motion engine for the Flappy Bird game: owns bird Y position, signed velocity and the IDLE/PLAY/DEAD game state.
- Sits upstream of the VGA renderer, which draws the bird at bird_y.
- Advances once per game tick (rising edge of clk_game from the clock divider); flap requests come from the player pushbutton, death requests from the collision detector.
- All logic runs on the 100 MHz master clock; clk_game and the button are sampled as data, never used as clocks.

Parameters:
Y_START, 240, reset/idle bird Y (pixels, top of sprite)
FLOOR_Y, 464, lowest legal Y (480 minus 16-pixel sprite); reaching it kills the bird
GRAVITY, 1, velocity increment per tick
FLAP_VEL, 6, flap impulse magnitude; velocity set to -FLAP_VEL
MAX_FALL, 8, terminal (maximum positive) velocity
DEAD_HOLD, 32, ticks in DEAD before a flap may return to IDLE

Ports:
clk  in  1  100 MHz master clock
clr  in  1  reset, asynchronous, active-low
clk_game  in  1  divided game clock, asynchronous to clk, sampled
flap_btn  in  1  debounced flap pushbutton, asynchronous, level
collide  in  1  collision flag, clk domain, level
bird_y  out  10  bird Y position, unsigned, 0..FLOOR_Y
bird_vel  out  8  bird velocity, two's complement, pixels/tick (+ = down)
state  out  2  00 IDLE, 01 PLAY, 10 DEAD (11 unused)
alive  out  1  high in IDLE and PLAY

Behaviour:
- Reset (clr low, asynchronous, any state or mid-operation): bird_y=Y_START, bird_vel=0, state=IDLE, alive=1; flap_pending, hold counter and all sync/edge flops cleared.
- clk_game: 2-flop synchronizer plus delay flop; tick = s2 & ~s3, a 1-clk strobe.
  - Updates land on the 3rd clk edge after clk_game rises.
- flap_btn: identical sync and edge path; flap_edge is a 1-clk strobe.
  - Held button produces one edge only.
- IDLE:
  - Position frozen; ticks ignored.
  - flap_edge -> PLAY, bird_vel=-FLAP_VEL, bird_y unchanged, flap_pending=0.
- PLAY, every clk:
  - flap_edge sets flap_pending; it stays set until consumed.
  - collide=1 -> DEAD on the next edge, no position update. This takes priority over a coincident tick.
  - On tick with collide=0:
    - sum = bird_y + bird_vel, evaluated as 11-bit signed.
    - vel_next = -FLAP_VEL if flap_pending or flap_edge, else min(bird_vel+GRAVITY, MAX_FALL).
    - If sum < 0 (ceiling): bird_y=0, bird_vel=0, regardless of flap.
    - Else if sum >= FLOOR_Y: bird_y=FLOOR_Y, bird_vel=0, state=DEAD.
    - Else: bird_y=sum, bird_vel=vel_next.
    - flap_pending cleared.
  - A flap_edge in the same cycle as the tick is applied by that tick.
- DEAD:
  - bird_y and bird_vel frozen; alive=0.
  - Hold counter zeroed on entry; increments per tick, saturating at DEAD_HOLD.
  - flap_edge while counter < DEAD_HOLD: ignored.
  - flap_edge once counter == DEAD_HOLD: -> IDLE, bird_y=Y_START, bird_vel=0.
- flap_pending is cleared on every state change.
- Single always block per register group; no latches.

Test Plan:
- Reset mid-flight: in PLAY with bird_y=300, bird_vel=5, pull clr low between edges -> outputs become 240/0/IDLE/alive=1 immediately, without waiting for clk.
- Start and arc: flap in IDLE -> state=01, bird_vel=-6 on the 3rd edge. No further flaps; successive ticks give bird_y 234, 229, 225, 222, 220, 219, 219, 220 and bird_vel -5, -4, -3, -2, -1, 0, 1, 2.
- Terminal velocity: from bird_vel=0 at bird_y=240, no flaps -> per-tick Y deltas 0, 1, ..., 7, 8, 8, 8; bird_vel never exceeds 8.
- Ceiling clamp: flap held so flap_edge occurs before every tick from bird_y=240 -> bird_y reaches 0 on tick 40 with bird_vel=-6. Tick 41 -> bird_y=0, bird_vel=0.
- Floor death: bird_y=460, bird_vel=8, tick -> bird_y=464, bird_vel=0, state=10, alive=0.
- Collision and hold:
  - collide=1 coincident with a tick at bird_y=200 -> state=DEAD, bird_y stays 200.
  - Flap after 10 ticks -> still DEAD.
  - Flap after 32 ticks -> IDLE, bird_y=240.
  - Further flap -> PLAY.
